// File: rtl/approx_mul_pkg.sv
// ---------------------------------------------------------------------------
// approx_mul_pkg
//
// Purpose : Shared constants, types and helpers for the 6x6 approximate
//           multiplier. The partial-product generator and the compressor
//           tree both use this package, so they agree on how the 36 AND
//           terms are packed column by column.
//
// Contents: MUL_W, NUM_COLS, NUM_PP   - operand width, column and term counts
//           COL_SIZE / COL_OFF        - bits per column, first bit of column
//           operand_t                 - packed a/b operand pair
//           pp_index(i,j)             - bit position of a[i] & b[j]
//           col_first_i(k)            - smallest i that lands in column k
//           trunc_bits(n)             - bits taken by columns 0..n-1
// ---------------------------------------------------------------------------
package approx_mul_pkg;

   localparam int MUL_W    = 6;
   localparam int NUM_COLS = 2 * MUL_W - 1;
   localparam int NUM_PP   = MUL_W * MUL_W;

   localparam int COL_SIZE [0:NUM_COLS-1] = '{1, 2, 3, 4, 5, 6, 5, 4, 3, 2, 1};
   localparam int COL_OFF  [0:NUM_COLS-1] = '{0, 1, 3, 6, 10, 15, 21, 26, 30, 33, 35};

   typedef struct packed {
      logic [MUL_W-1:0] a;
      logic [MUL_W-1:0] b;
   } operand_t;

   // Column k holds terms with i running from max(0, k-(MUL_W-1)) upward.
   function automatic int col_first_i(input int k);
      return (k > MUL_W - 1) ? (k - (MUL_W - 1)) : 0;
   endfunction

   // Bits are ordered by increasing i inside a column, so the position is
   // the column base plus the distance of i from the first i in that column.
   function automatic int pp_index(input int i, input int j);
      int k;
      k = i + j;
      return COL_OFF[k] + i - col_first_i(k);
   endfunction

   // Columns are contiguous and ordered, so the first n columns occupy
   // exactly the low trunc_bits(n) bits of the vector.
   function automatic int trunc_bits(input int n);
      return (n == 0) ? 0 : (COL_OFF[n-1] + COL_SIZE[n-1]);
   endfunction

endpackage

// File: rtl/pp_gen_pipe_if.sv
// ---------------------------------------------------------------------------
// pp_gen_pipe_if
//
// Purpose : Bundles the operand-side and reduction-side handshakes of the
//           partial-product generator.
//
// Signals : in_valid/in_ready/a/b/in_tag       - operand pair stream
//           out_valid/out_ready/pp/out_tag     - column-major partial products
//
// Modports: slave  - the generator (consumes operands, produces pp)
//           master - the surrounding logic (produces operands, consumes pp)
// ---------------------------------------------------------------------------
interface pp_gen_pipe_if
   import approx_mul_pkg::*;
#(
   parameter int TAG_W = 4
);

   logic              in_valid;
   logic              in_ready;
   logic [MUL_W-1:0]  a;
   logic [MUL_W-1:0]  b;
   logic [TAG_W-1:0]  in_tag;

   logic              out_valid;
   logic              out_ready;
   logic [NUM_PP-1:0] pp;
   logic [TAG_W-1:0]  out_tag;

   modport slave (
      input  in_valid, a, b, in_tag, out_ready,
      output in_ready, out_valid, pp, out_tag
   );

   modport master (
      output in_valid, a, b, in_tag, out_ready,
      input  in_ready, out_valid, pp, out_tag
   );

endinterface

// File: rtl/pp_pipe_reg.sv
// ---------------------------------------------------------------------------
// pp_pipe_reg
//
// Purpose : One valid/ready register slice. Holds a single data word and a
//           valid bit. It accepts a new word whenever it is empty or its
//           current word leaves downstream in the same cycle, so a chain of
//           these runs at one word per clock with no bubbles.
//
// Ports   : clk, rst_n        - clock, asynchronous active-low reset
//           valid_i, ready_o  - upstream handshake
//           data_i            - upstream data word (W bits)
//           valid_o, ready_i  - downstream handshake
//           data_o            - registered data word (W bits)
// ---------------------------------------------------------------------------
module pp_pipe_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         valid_i,
   output logic         ready_o,
   input  logic [W-1:0] data_i,
   output logic         valid_o,
   input  logic         ready_i,
   output logic [W-1:0] data_o
);

   logic         valid_q;
   logic         valid_d;
   logic [W-1:0] data_q;
   logic [W-1:0] data_d;
   logic         load;

   // Ready depends only on our own valid bit and downstream ready, never on
   // valid_i, so no combinational loop can form through the upstream stage.
   assign ready_o = !valid_q || ready_i;
   assign load    = valid_i && ready_o;

   // A load always wins; otherwise the word leaves when downstream takes it.
   // Data only changes on a load, which keeps it bit-stable during a stall.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end else if (ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/pp_gen_pipe.sv
// ---------------------------------------------------------------------------
// pp_gen_pipe
//
// Purpose : Pipelined partial-product generator for the 6x6 approximate
//           multiplier. Stage S1 registers the operand pair and tag. The
//           AND array then forms all 36 terms and packs them column-major,
//           with the lowest TRUNC_COLS columns forced to zero. Stage S2
//           registers that vector for the compressor tree.
//
// Params  : TRUNC_COLS - number of low columns zeroed (0..11, 0 = exact)
//           TAG_W      - sideband tag width
//
// Ports   : clk, rst_n - clock, asynchronous active-low reset
//           bus        - pp_gen_pipe_if slave (operand and pp handshakes)
// ---------------------------------------------------------------------------
module pp_gen_pipe
   import approx_mul_pkg::*;
#(
   parameter int TRUNC_COLS = 0,
   parameter int TAG_W      = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   pp_gen_pipe_if.slave   bus
);

   localparam int S1_W = 2 * MUL_W + TAG_W;
   localparam int S2_W = NUM_PP + TAG_W;

   // Truncated columns are the low contiguous bits, so one constant mask
   // clears them. Shifting by the full width leaves zero, which covers the
   // case where every column is truncated.
   localparam int                TRUNC_BITS = trunc_bits(TRUNC_COLS);
   localparam logic [NUM_PP-1:0] KEEP_MASK  = {NUM_PP{1'b1}} << TRUNC_BITS;

   operand_t          inOps;
   operand_t          s1Ops;
   logic [S1_W-1:0]   s1Data;
   logic [TAG_W-1:0]  s1Tag;
   logic              s1Valid;
   logic              s2Ready;
   logic [NUM_PP-1:0] ppRaw;
   logic [NUM_PP-1:0] ppMap;
   logic [S2_W-1:0]   s2Data;

   assign inOps.a = bus.a;
   assign inOps.b = bus.b;

   pp_pipe_reg #(
      .W (S1_W)
   ) uStage1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (bus.in_valid),
      .ready_o (bus.in_ready),
      .data_i  ({inOps, bus.in_tag}),
      .valid_o (s1Valid),
      .ready_i (s2Ready),
      .data_o  (s1Data)
   );

   assign s1Ops = s1Data[S1_W-1:TAG_W];
   assign s1Tag = s1Data[TAG_W-1:0];

   // AND array: every a[i] & b[j] goes to its column-major slot.
   always_comb begin
      ppRaw = '0;
      for (int i = 0; i < MUL_W; i++) begin
         for (int j = 0; j < MUL_W; j++) begin
            ppRaw[pp_index(i, j)] = s1Ops.a[i] & s1Ops.b[j];
         end
      end
   end

   assign ppMap = ppRaw & KEEP_MASK;

   pp_pipe_reg #(
      .W (S2_W)
   ) uStage2 (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (s1Valid),
      .ready_o (s2Ready),
      .data_i  ({ppMap, s1Tag}),
      .valid_o (bus.out_valid),
      .ready_i (bus.out_ready),
      .data_o  (s2Data)
   );

   assign bus.pp      = s2Data[S2_W-1:TAG_W];
   assign bus.out_tag = s2Data[TAG_W-1:0];

endmodule

// File: tb/tb_pp_gen_pipe.sv
// ---------------------------------------------------------------------------
// tb_pp_gen_pipe
//
// Purpose : Self-checking bench for pp_gen_pipe. Drives an exact instance
//           and a TRUNC_COLS=3 instance with the same operand stream.
// ---------------------------------------------------------------------------
module tb_pp_gen_pipe;

   logic clk;
   logic rst_n;

   int checkCount = 0;
   int errorCount = 0;

   pp_gen_pipe_if #(.TAG_W(4)) bus0 ();
   pp_gen_pipe_if #(.TAG_W(4)) bus1 ();

   pp_gen_pipe #(.TRUNC_COLS(0), .TAG_W(4)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   pp_gen_pipe #(.TRUNC_COLS(3), .TAG_W(4)) dut3 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   // The truncating instance sees exactly the same inputs as the exact one.
   assign bus1.in_valid  = bus0.in_valid;
   assign bus1.a         = bus0.a;
   assign bus1.b         = bus0.b;
   assign bus1.in_tag    = bus0.in_tag;
   assign bus1.out_ready = bus0.out_ready;

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference mapping: walk columns in order and hand out bit positions
   // sequentially, independent of any offset table.
   function automatic logic [35:0] refPp(input logic [5:0] a, input logic [5:0] b,
                                         input int trunc);
      logic [35:0] r;
      int          pos;
      int          j;
      r   = '0;
      pos = 0;
      for (int k = 0; k < 11; k++) begin
         for (int i = 0; i < 6; i++) begin
            j = k - i;
            if (j >= 0 && j < 6) begin
               if (k >= trunc) r[pos] = a[i] & b[j];
               pos++;
            end
         end
      end
      return r;
   endfunction

   // Single comparison point: counts every check, reports mismatches.
   task automatic checkOutput(input string name, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, observed, expected);
      end
   endtask

   // One operand pair with out_ready high: check ready, latency, and both
   // instances' outputs one edge after acceptance.
   task automatic applyStimulus(input string name, input logic [5:0] a, input logic [5:0] b,
                                input logic [3:0] tag, input logic [35:0] exp0,
                                input logic [35:0] exp3);
      @(negedge clk);
      bus0.in_valid  = 1'b1;
      bus0.a         = a;
      bus0.b         = b;
      bus0.in_tag    = tag;
      bus0.out_ready = 1'b1;
      #1;
      checkOutput({name, "_in_ready"}, 64'(bus0.in_ready), 64'd1);
      @(negedge clk);
      bus0.in_valid = 1'b0;
      #1;
      checkOutput({name, "_latency"}, 64'(bus0.out_valid), 64'd0);
      @(negedge clk);
      checkOutput({name, "_valid"}, 64'(bus0.out_valid), 64'd1);
      checkOutput({name, "_pp"},    64'(bus0.pp),        64'(exp0));
      checkOutput({name, "_tag"},   64'(bus0.out_tag),   64'(tag));
      checkOutput({name, "_pp_t3"}, 64'(bus1.pp),        64'(exp3));
   endtask

   logic [15:0] sbQueue [$];
   int          sent;
   int          received;
   bit          didReset;

   initial begin
      rst_n          = 1'b0;
      bus0.in_valid  = 1'b0;
      bus0.a         = '0;
      bus0.b         = '0;
      bus0.in_tag    = '0;
      bus0.out_ready = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_out_valid", 64'(bus0.out_valid), 64'd0);
      checkOutput("rst_pp",        64'(bus0.pp),        64'd0);
      checkOutput("rst_out_tag",   64'(bus0.out_tag),   64'd0);
      rst_n = 1'b1;
      #1;
      checkOutput("rst_in_ready",  64'(bus0.in_ready),  64'd1);

      // Directed vectors, hand-computed for TRUNC_COLS=0 and TRUNC_COLS=3
      applyStimulus("all_ones", 6'h3F, 6'h3F, 4'h5, 36'hF_FFFF_FFFF, 36'hF_FFFF_FFC0);
      applyStimulus("lsb_lsb",  6'h01, 6'h01, 4'h6, 36'h0_0000_0001, 36'h0_0000_0000);
      applyStimulus("a5_b0",    6'h20, 6'h01, 4'h7, 36'h0_0010_0000, 36'h0_0010_0000);
      applyStimulus("a0_b5",    6'h01, 6'h20, 4'h8, 36'h0_0000_8000, 36'h0_0000_8000);
      applyStimulus("three_sq", 6'h03, 6'h03, 4'h9, 36'h0_0000_0017, 36'h0_0000_0000);
      applyStimulus("a_by_b0",  6'h3F, 6'h01, 4'hA, 36'h0_0010_4225, 36'h0_0010_4200);

      // Let the last directed pair drain
      @(negedge clk);
      checkOutput("drained", 64'(bus0.out_valid), 64'd0);

      // Backpressure: out_ready low, tags 1,2,3 offered back to back
      bus0.out_ready = 1'b0;
      for (int t = 1; t <= 2; t++) begin
         bus0.in_valid = 1'b1;
         bus0.a        = 6'(t * 5);
         bus0.b        = 6'(t * 9);
         bus0.in_tag   = 4'(t);
         #1;
         checkOutput($sformatf("bp_accept%0d", t), 64'(bus0.in_ready), 64'd1);
         @(negedge clk);
      end
      bus0.a      = 6'd15;
      bus0.b      = 6'd27;
      bus0.in_tag = 4'd3;
      for (int c = 0; c < 4; c++) begin
         #1;
         checkOutput($sformatf("bp_full%0d", c), 64'(bus0.in_ready), 64'd0);
         checkOutput($sformatf("bp_tag%0d", c),  64'(bus0.out_tag),  64'd1);
         checkOutput($sformatf("bp_pp%0d", c),   64'(bus0.pp),
                     64'(refPp(6'd5, 6'd9, 0)));
         @(negedge clk);
      end
      bus0.out_ready = 1'b1;
      #1;
      checkOutput("bp_release_ready", 64'(bus0.in_ready), 64'd1);
      checkOutput("bp_out1",          64'(bus0.out_tag),  64'd1);
      @(negedge clk);
      bus0.in_valid = 1'b0;
      checkOutput("bp_out2_valid", 64'(bus0.out_valid), 64'd1);
      checkOutput("bp_out2",       64'(bus0.out_tag),   64'd2);
      checkOutput("bp_out2_pp",    64'(bus0.pp),        64'(refPp(6'd10, 6'd18, 0)));
      @(negedge clk);
      checkOutput("bp_out3_valid", 64'(bus0.out_valid), 64'd1);
      checkOutput("bp_out3",       64'(bus0.out_tag),   64'd3);
      checkOutput("bp_out3_pp",    64'(bus0.pp),        64'(refPp(6'd15, 6'd27, 0)));
      @(negedge clk);
      checkOutput("bp_empty", 64'(bus0.out_valid), 64'd0);

      // Random streaming with scoreboard and a reset in the middle
      sent     = 0;
      received = 0;
      didReset = 1'b0;
      for (int cyc = 0; cyc < 20000; cyc++) begin
         if (sent == 1000 && sbQueue.size() == 0) break;
         @(negedge clk);
         if (!didReset && sent >= 500) begin
            bus0.out_ready = 1'b0;
            bus0.in_valid  = 1'b0;
            rst_n          = 1'b0;
            #1;
            checkOutput("mid_rst_valid", 64'(bus0.out_valid), 64'd0);
            sbQueue.delete();
            @(negedge clk);
            @(negedge clk);
            rst_n    = 1'b1;
            didReset = 1'b1;
            #1;
            checkOutput("post_rst_valid", 64'(bus0.out_valid), 64'd0);
            continue;
         end
         bus0.out_ready = ($urandom_range(0, 9) < 7);
         if (sent < 1000 && $urandom_range(0, 3) != 0) begin
            bus0.in_valid = 1'b1;
            bus0.a        = 6'($urandom);
            bus0.b        = 6'($urandom);
            bus0.in_tag   = 4'(sent);
         end else begin
            bus0.in_valid = 1'b0;
         end
         #1;
         if (bus0.out_valid && bus0.out_ready) begin
            if (sbQueue.size() == 0) begin
               checkOutput("sb_unexpected", 64'd1, 64'd0);
            end else begin
               logic [15:0] e;
               e = sbQueue.pop_front();
               checkOutput("sb_pp",  64'(bus0.pp),      64'(refPp(e[15:10], e[9:4], 0)));
               checkOutput("sb_tag", 64'(bus0.out_tag), 64'(e[3:0]));
               received++;
            end
         end
         if (bus0.in_valid && bus0.in_ready) begin
            sbQueue.push_back({bus0.a, bus0.b, bus0.in_tag});
            sent++;
         end
      end
      checkOutput("stream_done", 64'(sent == 1000 && sbQueue.size() == 0), 64'd1);
      checkOutput("stream_reset_seen", 64'(didReset), 64'd1);
      checkOutput("stream_some_received", 64'(received > 400), 64'd1);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
